// File: rtl/synth_audio_pkg.sv
// Shared constants and the fetch FSM state type for the I2S scheduler.
package synth_audio_pkg;

  // Default sample width per channel.
  localparam int AUD_WIDTH  = 16;

  // BCK periods per LRCK frame (32 per channel).
  localparam int FRAME_BITS = 64;
  localparam int BITCNT_W   = $clog2(FRAME_BITS);

  // Sample fetch FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FULL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/audio_i2s_clkgen.sv
// BCK divider, 64-bit frame counter, LRCK and frame-start tick.
// While i_run is low everything is held at zero, so a restarted run always
// begins at the first bit of a fresh frame.
module audio_i2s_clkgen
  import synth_audio_pkg::*;
#(
  parameter int BCK_HALF_DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_bck,
  output logic o_lrck,
  output logic o_tick
);

  localparam logic [7:0]          DIV_LAST = 8'(BCK_HALF_DIV - 1);
  localparam logic [BITCNT_W-1:0] BIT_LAST = BITCNT_W'(FRAME_BITS - 1);

  logic [7:0]          r_div;
  logic                r_bck;
  logic [BITCNT_W-1:0] r_bitcnt;
  logic                r_tick;
  logic                w_term;

  assign w_term = (r_div == DIV_LAST);

  // Divider toggles BCK on terminal count; bit counter advances on BCK fall,
  // and the tick is raised in the same edge where the counter wraps 63->0.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_div    <= '0;
      r_bck    <= 1'b0;
      r_bitcnt <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_term) begin
        r_div <= '0;
        r_bck <= ~r_bck;
        if (r_bck) begin
          r_bitcnt <= r_bitcnt + BITCNT_W'(1);
          r_tick   <= (r_bitcnt == BIT_LAST);
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  // LRCK is the counter MSB, so it can only move on a BCK falling edge.
  assign o_bck  = r_bck;
  assign o_lrck = r_bitcnt[BITCNT_W-1];
  assign o_tick = r_tick;

endmodule

// File: rtl/audio_i2s_scheduler.sv
// I2S frame scheduler: generates BCK/LRCK, fetches one stereo pair per
// frame from the synth engine and presents it, stable, for a whole frame.
//
// Handshake: oSAMPLE_REQ acts as ready, iSAMPLE_VALID as valid. A pair moves
// on any rising iCLK edge where both are high; the requester may hold valid
// high with data at any time, and the data is only consumed on that edge.
module audio_i2s_scheduler
  import synth_audio_pkg::*;
#(
  parameter int BCK_HALF_DIV = 8,
  parameter int AUD_WIDTH    = synth_audio_pkg::AUD_WIDTH
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iENABLE,
  output logic                 oAUD_BCK,
  output logic                 oAUD_LRCK,
  output logic                 oFRAME_TICK,
  output logic                 oSAMPLE_REQ,
  input  logic                 iSAMPLE_VALID,
  input  logic [AUD_WIDTH-1:0] i_lsample,
  input  logic [AUD_WIDTH-1:0] i_rsample,
  output logic [AUD_WIDTH-1:0] o_lsound_out,
  output logic [AUD_WIDTH-1:0] o_rsound_out,
  output logic                 oUNDERRUN,
  input  logic                 iCLR_UNDERRUN,
  output fetch_state_t         o_dbg_state
);

  fetch_state_t         r_state;
  fetch_state_t         w_state_next;
  logic [AUD_WIDTH-1:0] r_stage_l;
  logic [AUD_WIDTH-1:0] r_stage_r;
  logic [AUD_WIDTH-1:0] r_out_l;
  logic [AUD_WIDTH-1:0] r_out_r;
  logic                 r_underrun;

  logic w_tick;
  logic w_hs;
  logic w_run;
  logic w_capture;
  logic w_load_in;
  logic w_load_stage;
  logic w_zero_out;
  logic w_set_ur;

  // Counters run whenever the FSM is (or is about to be) out of IDLE, so an
  // enable drop only stops them once the frame-end tick has been consumed.
  assign w_run = (w_state_next != ST_IDLE);

  audio_i2s_clkgen #(
    .BCK_HALF_DIV(BCK_HALF_DIV)
  ) u_clkgen (
    .i_clk (iCLK),
    .i_rst (iRST),
    .i_run (w_run),
    .o_bck (oAUD_BCK),
    .o_lrck(oAUD_LRCK),
    .o_tick(w_tick)
  );

  assign oSAMPLE_REQ = (r_state == ST_REQ);
  assign w_hs        = oSAMPLE_REQ & iSAMPLE_VALID;

  // Next-state and datapath strobes for the fetch FSM.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_load_in    = 1'b0;
    w_load_stage = 1'b0;
    w_zero_out   = 1'b0;
    w_set_ur     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iENABLE) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (w_tick) begin
          // A pair arriving on the tick itself bypasses the stage.
          if (w_hs) begin
            w_load_in = 1'b1;
          end else begin
            w_zero_out = 1'b1;
            w_set_ur   = 1'b1;
          end
          w_state_next = iENABLE ? ST_REQ : ST_IDLE;
        end else if (w_hs) begin
          w_capture    = 1'b1;
          w_state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_tick) begin
          w_load_stage = 1'b1;
          w_state_next = iENABLE ? ST_REQ : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, stage, output pair and sticky underrun registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= ST_IDLE;
      r_stage_l  <= '0;
      r_stage_r  <= '0;
      r_out_l    <= '0;
      r_out_r    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_stage_l <= i_lsample;
        r_stage_r <= i_rsample;
      end else if (w_state_next == ST_IDLE) begin
        r_stage_l <= '0;
        r_stage_r <= '0;
      end
      if (w_load_in) begin
        r_out_l <= i_lsample;
        r_out_r <= i_rsample;
      end else if (w_load_stage) begin
        r_out_l <= r_stage_l;
        r_out_r <= r_stage_r;
      end else if (w_zero_out) begin
        r_out_l <= '0;
        r_out_r <= '0;
      end
      // A fresh underrun beats a simultaneous clear.
      if (w_set_ur) begin
        r_underrun <= 1'b1;
      end else if (iCLR_UNDERRUN) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign oFRAME_TICK  = w_tick;
  assign o_lsound_out = r_out_l;
  assign o_rsound_out = r_out_r;
  assign oUNDERRUN    = r_underrun;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_audio_i2s_scheduler.sv
// Directed-plus-random bench for audio_i2s_scheduler with a cycle-count
// reference model of the audio clocks and a one-deep pair buffer model.
module tb_audio_i2s_scheduler;
  import synth_audio_pkg::*;

  localparam int N     = 8;
  localparam int W     = 16;
  localparam int FRAME = 128 * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en;
  logic         valid;
  logic         clr;
  logic [W-1:0] lin;
  logic [W-1:0] rin;

  logic         o_bck;
  logic         o_lrck;
  logic         o_tick;
  logic         o_req;
  logic [W-1:0] o_l;
  logic [W-1:0] o_r;
  logic         o_ur;
  fetch_state_t o_state;

  audio_i2s_scheduler #(
    .BCK_HALF_DIV(N),
    .AUD_WIDTH   (W)
  ) dut (
    .iCLK         (clk),
    .iRST         (rst),
    .iENABLE      (en),
    .oAUD_BCK     (o_bck),
    .oAUD_LRCK    (o_lrck),
    .oFRAME_TICK  (o_tick),
    .oSAMPLE_REQ  (o_req),
    .iSAMPLE_VALID(valid),
    .i_lsample    (lin),
    .i_rsample    (rin),
    .o_lsound_out (o_l),
    .o_rsound_out (o_r),
    .oUNDERRUN    (o_ur),
    .iCLR_UNDERRUN(clr),
    .o_dbg_state  (o_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // m_c counts clock edges since the run started; the audio clocks are
  // plain arithmetic on it. The pair path is a one-deep buffer.
  bit           m_active = 1'b0;
  int           m_c      = 0;
  bit           m_full   = 1'b0;
  bit           m_ur     = 1'b0;
  logic [W-1:0] m_stage_l = '0;
  logic [W-1:0] m_stage_r = '0;
  logic [W-1:0] m_out_l   = '0;
  logic [W-1:0] m_out_r   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs now driven.
  task automatic model_update();
    bit tick_now;
    bit hs;
    bit set_ur;
    tick_now = m_active && (m_c > 0) && ((m_c % FRAME) == 0);
    hs       = m_active && !m_full && valid;
    set_ur   = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_c = 0; m_full = 1'b0; m_ur = 1'b0;
      m_stage_l = '0; m_stage_r = '0; m_out_l = '0; m_out_r = '0;
    end else begin
      if (!m_active) begin
        if (en) begin
          m_active = 1'b1;
          m_c      = 1;
        end
      end else if (tick_now) begin
        if (m_full) begin
          m_out_l = m_stage_l; m_out_r = m_stage_r;
        end else if (hs) begin
          m_out_l = lin; m_out_r = rin;
        end else begin
          m_out_l = '0; m_out_r = '0; set_ur = 1'b1;
        end
        m_full = 1'b0;
        if (en) m_c++;
        else begin
          m_active = 1'b0; m_c = 0;
        end
      end else begin
        if (hs) begin
          m_full = 1'b1; m_stage_l = lin; m_stage_r = rin;
        end
        m_c++;
      end
      if (set_ur) m_ur = 1'b1;
      else if (clr) m_ur = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic         e_bck;
    logic         e_lrck;
    logic         e_tick;
    fetch_state_t e_state;
    e_bck   = m_active ? (((m_c / N) % 2) == 1) : 1'b0;
    e_lrck  = m_active ? (((m_c / (2 * N)) % 64) >= 32) : 1'b0;
    e_tick  = m_active && (m_c > 0) && ((m_c % FRAME) == 0);
    e_state = !m_active ? ST_IDLE : (m_full ? ST_FULL : ST_REQ);
    chk("bck",   o_bck,   e_bck);
    chk("lrck",  o_lrck,  e_lrck);
    chk("tick",  o_tick,  e_tick);
    chk("req",   o_req,   (e_state == ST_REQ));
    chk("out_l", o_l,     m_out_l);
    chk("out_r", o_r,     m_out_r);
    chk("ur",    o_ur,    m_ur);
    chk("state", o_state, e_state);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model sits at frame position pos (pre-edge).
  task automatic run_until_pos(input int pos);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < FRAME + 8; i++) begin
      if (m_active && ((m_c % FRAME) == pos)) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    chk("reach_pos", reached, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; clr = 1'b0; lin = '0; rin = '0;
    #1;
    run(3);
    rst = 1'b0;
    run(4);

    // Free-running with no requester: clocks, first tick, underrun.
    en = 1'b1;
    run(FRAME + 20);
    chk("ur_after_first_tick", o_ur, 1'b1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("ur_cleared", o_ur, 1'b0);

    // Early handshake staged, presented at the following tick.
    run_until_pos(100);
    valid = 1'b1; lin = 16'h1234; rin = 16'hABCD;
    step();
    valid = 1'b0; lin = $urandom; rin = $urandom;
    chk("req_drop_after_hs", o_req, 1'b0);
    run_until_pos(0);
    step();
    chk("staged_l", o_l, 16'h1234);
    chk("staged_r", o_r, 16'hABCD);
    run_until_pos(0);
    chk("hold_l", o_l, 16'h1234);
    step();
    clr = 1'b1; step(); clr = 1'b0;

    // Handshake landing exactly on the tick.
    run_until_pos(0);
    valid = 1'b1; lin = 16'h7FFF; rin = 16'h8000;
    step();
    valid = 1'b0;
    chk("bypass_l", o_l, 16'h7FFF);
    chk("bypass_r", o_r, 16'h8000);
    chk("bypass_no_ur", o_ur, 1'b0);
    chk("bypass_req", o_req, 1'b1);

    // Random requester and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 7) == 0);
      lin   = W'($urandom);
      rin   = W'($urandom);
      clr   = ($urandom_range(0, 199) == 0);
      step();
    end
    valid = 1'b0; clr = 1'b0;

    // Clear on the same edge as a second underrun: set wins.
    run_until_pos(0); step();
    run_until_pos(0); step();
    run_until_pos(0);
    clr = 1'b1; step(); clr = 1'b0;
    chk("set_beats_clear", o_ur, 1'b1);

    // Enable dropped at bit 20: frame completes, then everything stops.
    run_until_pos(20 * 2 * N);
    en = 1'b0;
    run(FRAME);
    chk("idle_after_drop", o_state, ST_IDLE);
    chk("bck_after_drop", o_bck, 1'b0);

    // Reset while the stage is full overrides enable and handshake.
    en = 1'b1;
    run_until_pos(50);
    valid = 1'b1; lin = W'($urandom); rin = W'($urandom);
    step();
    valid = 1'b0;
    run_until_pos(500);
    chk("full_before_rst", o_state, ST_FULL);
    rst = 1'b1; valid = 1'b1;
    step();
    chk("rst_state", o_state, ST_IDLE);
    chk("rst_out_l", o_l, '0);
    chk("rst_bck", o_bck, 1'b0);
    rst = 1'b0; valid = 1'b0; en = 1'b0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_i2s_scheduler.md
AUDIO_I2S_SCHEDULER -- requirements
Module: audio_i2s_scheduler

Interface
REQ-001 Parameter BCK_HALF_DIV SHALL default to 8; it is the number of iCLK cycles per oAUD_BCK half-period, with a legal range of 2..255.
REQ-002 Parameter AUD_WIDTH SHALL default to 16; it is the sample width per channel.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port iCLK SHALL be: in, 1 bit, system clock; all logic on its rising edge.
REQ-005 Port iRST SHALL be: in, 1 bit, synchronous active-high reset.
REQ-006 Port iENABLE SHALL be: in, 1 bit, run request for the audio clocks and the fetch.
REQ-007 Port oAUD_BCK SHALL be: out, 1 bit, registered I2S bit clock.
REQ-008 Port oAUD_LRCK SHALL be: out, 1 bit, registered word select; 0 = left, 1 = right.
REQ-009 Port oFRAME_TICK SHALL be: out, 1 bit, one-iCLK pulse at frame start.
REQ-010 Port oSAMPLE_REQ SHALL be: out, 1 bit, request to the synth engine for the next stereo pair.
REQ-011 Port iSAMPLE_VALID SHALL be: in, 1 bit, pair valid; a transfer occurs when it and oSAMPLE_REQ are both high.
REQ-012 Ports i_lsample and i_rsample SHALL be: in, AUD_WIDTH bits each, the offered left/right pair.
REQ-013 Ports o_lsound_out and o_rsound_out SHALL be: out, AUD_WIDTH bits each, registered pair fed to the I2S serializer.
REQ-014 Port oUNDERRUN SHALL be: out, 1 bit, sticky underrun flag.
REQ-015 Port iCLR_UNDERRUN SHALL be: in, 1 bit, clears oUNDERRUN.

Function
REQ-016 The divider SHALL count 0..BCK_HALF_DIV-1 and toggle oAUD_BCK on the terminal count; the BCK period is 2*BCK_HALF_DIV iCLK cycles.
REQ-017 A 6-bit bit counter SHALL advance on each oAUD_BCK 1->0 toggle and wrap 63->0; oAUD_LRCK SHALL equal bit counter bit 5, so each frame is 64 BCK with 32 bits per channel.
REQ-018 oAUD_LRCK SHALL change only in the iCLK cycle where oAUD_BCK falls.
REQ-019 oFRAME_TICK SHALL pulse for exactly one cycle when the bit counter wraps 63->0; the frame period is 128*BCK_HALF_DIV cycles (1024 at default).
REQ-020 The fetch FSM SHALL have states IDLE, REQ and FULL.
REQ-021 In IDLE, oSAMPLE_REQ SHALL be 0 and the divider, bit counter, oAUD_BCK and oAUD_LRCK SHALL be held at 0.
REQ-022 IDLE->REQ SHALL occur when iENABLE=1; the counters start that cycle, and the first oFRAME_TICK occurs 128*BCK_HALF_DIV cycles later.
REQ-023 oSAMPLE_REQ SHALL be 1 exactly in state REQ.
REQ-024 REQ with a handshake and no tick: the pair SHALL be captured into the stage registers, then REQ->FULL.
REQ-025 FULL with a tick: the stage SHALL be copied to the outputs, then FULL->REQ.
REQ-026 REQ with a tick and a handshake in the same cycle: the inputs SHALL go directly to the outputs, no underrun is flagged, and the FSM stays in REQ.
REQ-027 REQ with a tick and no handshake (underrun): the outputs SHALL be set to 0, oUNDERRUN set to 1, and the FSM stays in REQ.
REQ-028 o_lsound_out and o_rsound_out SHALL change only in oFRAME_TICK cycles, so they are stable over the whole frame.
REQ-029 Deasserting iENABLE mid-frame SHALL take effect at the next tick: that tick's transfer still occurs, then the FSM enters IDLE with the counters cleared and a pending stage discarded; frames are never truncated.
REQ-030 While iCLR_UNDERRUN=1, oUNDERRUN SHALL be 0; if a clear and a new underrun occur in the same cycle, set wins and oUNDERRUN=1.

Reset
REQ-031 iRST SHALL clear the FSM to IDLE, the divider, bit counter, oAUD_BCK, oAUD_LRCK, oFRAME_TICK, oSAMPLE_REQ, oUNDERRUN, the stage registers and both sound outputs to 0.
REQ-032 iRST asserted mid-frame SHALL take effect in the next cycle and override iENABLE and any handshake.

Structure
REQ-033 Shared package synth_audio_pkg SHALL hold AUD_WIDTH, FRAME_BITS=64 and the FSM state enum.
REQ-034 The divider and bit counter SHALL be one sub-module, audio_i2s_clkgen, with outputs BCK, LRCK and frame tick.

Verification
REQ-035 Enable with BCK_HALF_DIV=8, no requester: BCK period is 16 cycles, LRCK period 1024 cycles, first tick at cycle 1024, and oUNDERRUN=1 after it.
REQ-036 Handshake 0x1234/0xABCD at cycle 100: REQ drops the next cycle, the outputs stay 0 until the tick, then hold 0x1234/0xABCD for 1024 cycles.
REQ-037 Valid held back until the tick cycle with pair 0x7FFF/0x8000: the outputs take 0x7FFF/0x8000 in that cycle, oUNDERRUN stays 0, and REQ stays 1.
REQ-038 Enable dropped at bit 20: BCK and LRCK keep running to bit 63, and all stop at 0 after the tick.
REQ-039 Underrun, then iCLR_UNDERRUN pulsed in the same cycle as a second underrun: oUNDERRUN stays 1.
REQ-040 iRST pulsed mid-frame while the stage is FULL: the next cycle shows all outputs 0 and the FSM in IDLE.
